// File: rtl/tcb_lib_arbiter_if.sv
// Request/grant bundle between the TCB requesters, the arbiter and the downstream multiplexer.
// The master modport is the requesting side; the slave modport is the arbiter.
interface tcb_lib_arbiter_if #(
  parameter int SPN = 2
);
  localparam int SPL = $clog2(SPN);

  logic [SPN-1:0] vld;
  logic [SPN-1:0] lck;
  logic           rdy;
  logic [SPL-1:0] sel;
  logic [SPN-1:0] gnt;
  logic           trn;

  modport master (output vld, lck, rdy, input  sel, gnt, trn);
  modport slave  (input  vld, lck, rdy, output sel, gnt, trn);
endinterface

// File: rtl/tcb_lib_arbiter.sv
// TCB multiplexer arbiter: zero-latency grant in IDLE, ownership held across stalls (HOLD)
// and across locked bursts (LOCK) with a bounded burst length of LKM transfers.
module tcb_lib_arbiter #(
  parameter int SPN = 2,
  parameter int RRB = 1,
  parameter int LKM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  tcb_lib_arbiter_if.slave bus
);
  localparam int SPL = $clog2(SPN);
  localparam int CW  = $clog2(LKM + 1);

  typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

  state_t         state, state_n;
  logic [SPL-1:0] ptr, ptr_n, owner, owner_n;
  logic [SPL-1:0] base, winner, sel_c, sel_inc;
  logic [CW-1:0]  cnt, cnt_n;
  logic [SPN-1:0] gnt_c;
  logic           any, trn_c;

  function automatic logic [SPL-1:0] rot(input logic [SPL-1:0] p, input int i);
    return SPL'((int'(p) + i) % SPN);
  endfunction

  // Scan in reverse so the last hit (highest priority) is the one that sticks.
  assign base = (RRB != 0) ? ptr : '0;
  assign any  = |bus.vld;

  always_comb begin
    winner = '0;
    for (int i = SPN - 1; i >= 0; i--)
      if (bus.vld[rot(base, i)]) winner = rot(base, i);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  // output logic: sel never depends on rdy; gnt/trn are forced low while in reset
  always_comb begin
    sel_c = owner;
    gnt_c = '0;
    if (state == IDLE) begin
      if (any) begin
        sel_c         = winner;
        gnt_c[winner] = 1'b1;
      end
    end else begin
      gnt_c[owner] = 1'b1;
    end
    if (!rst_n) begin
      sel_c = '0;
      gnt_c = '0;
    end
  end

  assign trn_c   = gnt_c[sel_c] & bus.vld[sel_c] & bus.rdy;
  assign sel_inc = (sel_c == SPL'(SPN - 1)) ? '0 : sel_c + 1'b1;

  // next-state logic; a transfer overrides every per-state decision
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    case (state)
      IDLE: if (any && !trn_c) begin
        owner_n = winner;
        state_n = HOLD;
      end
      HOLD: if (!bus.vld[owner]) state_n = IDLE;
      LOCK: if (!bus.vld[owner] && !bus.lck[owner]) begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    if (trn_c) begin
      owner_n = sel_c;
      ptr_n   = (RRB != 0) ? sel_inc : ptr;
      if (bus.lck[sel_c] && (int'(cnt) + 1 < LKM)) begin
        state_n = LOCK;
        cnt_n   = cnt + 1'b1;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end
  end

  assign bus.sel = sel_c;
  assign bus.gnt = gnt_c;
  assign bus.trn = trn_c;
endmodule

// File: doc/tcb_lib_arbiter.md
TCB_LIB_ARBITER -- requirements
Module: tcb_lib_arbiter

Interface
REQ-001 Parameter SPN, default 2, number of requesting TCB subordinate ports of the downstream multiplexer (2..16).
REQ-002 Parameter SPL, localparam $clog2(SPN), select width.
REQ-003 Parameter RRB, default 1, 1 = round-robin priority, 0 = fixed priority (lowest index wins).
REQ-004 Parameter LKM, default 4, maximum consecutive locked transfers per owner before forced release (1..255).
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 vld  input  SPN  per-port request valid (sub[i].vld).
REQ-008 lck  input  SPN  per-port lock request; keep ownership after the current transfer.
REQ-009 rdy  input  1  manager-side ready (man.rdy).
REQ-010 sel  output  SPL  multiplexer select, drives the multiplexer sel port.
REQ-011 gnt  output  SPN  one-hot grant; all zero when no port owns the bus.
REQ-012 trn  output  1  transfer strobe, gnt[sel] & vld[sel] & rdy.

Function
REQ-013 States: IDLE (free arbitration), HOLD (granted request stalled, rdy=0), LOCK (owner retains bus between transfers).
REQ-014 IDLE: winner computed combinationally in the same cycle from vld and priority pointer ptr; zero-cycle grant latency.
REQ-015 IDLE, RRB=1: winner = first asserted vld at index ptr, ptr+1, ... wrapping modulo SPN; RRB=0: lowest asserted index.
REQ-016 IDLE, no vld asserted: gnt = 0, sel = owner register (last owner), no state change.
REQ-017 HOLD and LOCK: sel = owner, gnt = one-hot(owner); all other vld are ignored.
REQ-018 IDLE winner with rdy=0: owner <= winner, next state HOLD.
REQ-019 HOLD: while vld[owner]=1 and rdy=0, remain HOLD; vld[owner]=0 (protocol violation) -> IDLE next cycle, ptr unchanged.
REQ-020 On every trn (any state): owner <= sel; RRB=1: ptr <= (sel+1) mod SPN; RRB=0: ptr unchanged (0).
REQ-021 On trn with lck[sel]=1 and cnt+1 < LKM: next state LOCK, cnt <= cnt+1.
REQ-022 On trn with lck[sel]=0, or cnt+1 = LKM: next state IDLE, cnt <= 0 (forced release, lck ignored).
REQ-023 LOCK, vld[owner]=1 and rdy=0: stay LOCK (stall inside lock); LOCK, vld[owner]=0 and lck[owner]=0: IDLE, cnt <= 0.
REQ-024 LOCK, vld[owner]=0 and lck[owner]=1: stay LOCK, gnt held, bus idle.
REQ-025 cnt width $clog2(LKM+1); never exceeds LKM-1; no wrap.
REQ-026 Back-to-back: trn in cycle N returning to IDLE allows a new winner (possibly another port) in cycle N+1 with no bubble.
REQ-027 gnt and sel are stable (no change) while gnt[sel]=1 and vld[sel]=1 and rdy=0, satisfying TCB request stability.
REQ-028 Outputs gnt, trn depend combinationally on vld, lck, rdy only through arbitration; no combinational path from rdy to sel.

Reset
REQ-029 rst_n=0 asynchronously forces state=IDLE, ptr=0, owner=0, cnt=0.
REQ-030 During reset: sel=0, gnt=0, trn=0 regardless of inputs.
REQ-031 Reset asserted mid-HOLD or mid-LOCK abandons ownership; first cycle after release arbitrates from ptr=0.

Verification
REQ-032 SPN=4, RRB=1, vld=4'b1111, rdy=1 constantly -> sel sequence 0,1,2,3,0 with trn=1 every cycle.
REQ-033 SPN=4, vld=4'b0100, rdy=0 for 3 cycles then 1; vld[0] asserted in cycle 2 -> sel=2 held 4 cycles, trn in cycle 4 only, then sel=0.
REQ-034 LKM=4, vld=4'b0011, lck[1]=1, ptr=1, rdy=1 -> four consecutive transfers on port 1, then forced release, sel=0 next.
REQ-035 RRB=0, vld=4'b1010, rdy=1 -> sel=1 every cycle, port 3 starved; deassert vld[1] -> sel=3.
REQ-036 rst_n=0 pulse while state=LOCK owner=2 -> gnt=0 immediately; after release with vld=4'b1100 -> sel=2 (ptr=0 scan).
REQ-037 HOLD owner=1, vld[1] drops with rdy=0 -> IDLE next cycle, trn never asserted, ptr unchanged.
